// File: rtl/nic_output_packetizer.sv
// -----------------------------------------------------------------------------
// nic_output_packetizer
//
// NIC output stage. Accepts PE results through a valid/ready handshake into a
// small circular result queue and serialises each queued result as a wormhole
// packet toward the router local input port:
//    header, PAYLOAD_FLITS payload flits (low slice first), "NUL1", "NUL2"
// A packet is only started when the credit counter covers the whole packet,
// so flits of one packet always leave on consecutive cycles.
//
// Optional build macro: NIC_TRAILER_CHECKSUM_EN
//    When defined, the final trailer flit carries the XOR of the header and
//    all payload flits of the queue head entry instead of "NUL2".
//
// Ports:
//    clk                  clock, all state on the rising edge
//    reset                asynchronous, active-low reset
//    result_valid_din     PE offers a result this cycle
//    result_ready_dout    queue can accept a result (registered state only)
//    header_din           header flit for the offered result (nonzero)
//    payload_din          result payload, slice i = [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//    credit_in_din        one router buffer slot freed
//    output_channel_dout  registered flit toward the router, 0 when idle
//    zero_credits_dout    credit counter is zero
//    busy_dout            a packet is being sent
//    credit_error_dout    sticky: credit returned while counter already full
// -----------------------------------------------------------------------------
module nic_output_packetizer #(
   parameter int CHANNEL_WIDTH = 32,
   parameter int PAYLOAD_FLITS = 2,
   parameter int QUEUE_DEPTH   = 2,
   parameter int CREDITS       = 5
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   result_valid_din,
   output logic                                   result_ready_dout,
   input  logic [CHANNEL_WIDTH-1:0]               header_din,
   input  logic [PAYLOAD_FLITS*CHANNEL_WIDTH-1:0] payload_din,
   input  logic                                   credit_in_din,
   output logic [CHANNEL_WIDTH-1:0]               output_channel_dout,
   output logic                                   zero_credits_dout,
   output logic                                   busy_dout,
   output logic                                   credit_error_dout
);

   localparam int PACKET_FLITS = PAYLOAD_FLITS + 3;
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int IDX_W = $clog2(PACKET_FLITS);
   localparam int CRD_W = $clog2(CREDITS + 1);
   localparam int PAY_W = PAYLOAD_FLITS * CHANNEL_WIDTH;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QUEUE_DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PACKET_FLITS - 1);
   localparam logic [IDX_W-1:0] IDX_NUL1  = IDX_W'(PAYLOAD_FLITS + 1);
   localparam logic [CRD_W-1:0] CRD_FULL  = CRD_W'(CREDITS);
   localparam logic [CRD_W-1:0] CRD_PKT   = CRD_W'(PACKET_FLITS);

   // Trailer constants, right-aligned ASCII
   localparam logic [CHANNEL_WIDTH-1:0] FLIT_NUL1 = CHANNEL_WIDTH'(32'h4E55_4C31);
`ifndef NIC_TRAILER_CHECKSUM_EN
   localparam logic [CHANNEL_WIDTH-1:0] FLIT_NUL2 = CHANNEL_WIDTH'(32'h4E55_4C32);
`endif

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // ---------------------------------------------------------------- state
   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [CHANNEL_WIDTH-1:0]   out_q, out_d;
   logic [CRD_W-1:0]           credits_q, credits_d;
   logic                       err_q, err_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;

   // Queue storage; entries need no reset since count_q gates their use.
   logic [CHANNEL_WIDTH-1:0]   hdr_mem [QUEUE_DEPTH];
   logic [PAY_W-1:0]           pay_mem [QUEUE_DEPTH];

   logic                       push, pop;
   logic [CHANNEL_WIDTH-1:0]   head_hdr;
   logic [PAY_W-1:0]           head_pay;
   logic [CHANNEL_WIDTH-1:0]   pay_slice [PAYLOAD_FLITS];
   logic [CHANNEL_WIDTH-1:0]   trailer_flit;
   logic [CHANNEL_WIDTH-1:0]   send_flit;
   logic                       send_dec;

   // ---------------------------------------------------------------- queue
   assign result_ready_dout = (count_q != CNT_FULL);
   // Ready comes from registered count only, so a same-cycle pop never
   // opens a slot for a push into a full queue.
   assign push = result_valid_din && result_ready_dout;

   always_ff @(posedge clk) begin
      if (push) begin
         hdr_mem[wr_ptr_q] <= header_din;
         pay_mem[wr_ptr_q] <= payload_din;
      end
   end

   assign head_hdr = hdr_mem[rd_ptr_q];
   assign head_pay = pay_mem[rd_ptr_q];

   generate
      for (genvar gi = 0; gi < PAYLOAD_FLITS; gi++) begin : g_slice
         assign pay_slice[gi] = head_pay[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
   endgenerate

   // Explicit wrap so non-power-of-2 depths work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------- trailer
`ifdef NIC_TRAILER_CHECKSUM_EN
   always_comb begin
      trailer_flit = head_hdr;
      for (int i = 0; i < PAYLOAD_FLITS; i++) begin
         trailer_flit = trailer_flit ^ pay_slice[i];
      end
   end
`else
   assign trailer_flit = FLIT_NUL2;
`endif

   // Flit selected by the current index while in SEND (index >= 1).
   always_comb begin
      send_flit = trailer_flit;
      if (idx_q == IDX_NUL1) begin
         send_flit = FLIT_NUL1;
      end
      for (int i = 0; i < PAYLOAD_FLITS; i++) begin
         if (idx_q == IDX_W'(i + 1)) begin
            send_flit = pay_slice[i];
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      out_d   = '0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Whole-packet credit check: no mid-packet bubbles.
            if ((count_q != '0) && (credits_q >= CRD_PKT)) begin
               out_d   = head_hdr;
               idx_d   = IDX_W'(1);
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            out_d = send_flit;
            if (idx_q == IDX_LAST) begin
               pop     = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- credits
   assign send_dec = (out_d != '0);

   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (credit_in_din && !send_dec) begin
         if (credits_q == CRD_FULL) begin
            err_d = 1'b1;                  // saturate and flag
         end else begin
            credits_d = credits_q + 1'b1;
         end
      end else if (!credit_in_din && send_dec) begin
         credits_d = credits_q - 1'b1;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         out_q     <= '0;
         credits_q <= CRD_FULL;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
         credits_q <= credits_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   assign output_channel_dout = out_q;
   assign zero_credits_dout   = (credits_q == '0);
   assign busy_dout           = (state_q == ST_SEND);
   assign credit_error_dout   = err_q;

endmodule
